// File: rtl/shifter_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA, ROR when SHIFTER_ROTATE_EN is defined), up to STEP bits per cycle.
// Latency: ceil(shamt/STEP)+1 cycles from the accept edge to out_valid; shamt==0 takes 1 cycle.
// Backpressure: one op in flight; in_ready only in IDLE; the result is held in DONE until out_ready.
module shifter_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [XLEN-1:0]          a,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          result,
  output logic                     busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] work, work_shift, upper;
  logic [SW-1:0]   rem;
  logic [1:0]      opr;
  logic            sign;
  logic [SW:0]     k;
  logic            accept, zero_lat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = out_valid ? work : '0;
  assign accept    = in_valid && in_ready;

`ifdef SHIFTER_ROTATE_EN
  assign zero_lat = (shamt == '0);
`else
  // Without rotate hardware, op 11 is a pass-through that completes like shamt==0.
  assign zero_lat = (shamt == '0) || (op == 2'b11);
`endif

  // k = min(remaining, STEP); one extra bit so STEP==XLEN still fits.
  always_comb begin
    k = (SW+1)'(STEP);
    if ({1'b0, rem} < (SW+1)'(STEP))
      k = {1'b0, rem};
  end

  always_comb begin
    upper = '0;
    case (opr)
      2'b10:   upper = {XLEN{sign}};
`ifdef SHIFTER_ROTATE_EN
      2'b11:   upper = work;
`endif
      default: upper = '0;
    endcase
    if (opr == 2'b00)
      work_shift = work << k;
    else
      work_shift = XLEN'({upper, work} >> k);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_lat ? DONE : SHIFT;
      SHIFT:   if ({1'b0, rem} == k) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      rem  <= '0;
      opr  <= '0;
      sign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          work <= a;
          opr  <= op;
          sign <= a[XLEN-1];
          rem  <= zero_lat ? '0 : shamt;
        end
        SHIFT: begin
          work <= work_shift;
          rem  <= rem - k[SW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_unit.sv
// Randomized and directed checks of shifter_unit (XLEN=32, STEP=4) against a plain-arithmetic model.
module tb_shifter_unit;

  localparam int XLEN = 32;
  localparam int STEP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [XLEN-1:0]   a;
  logic [4:0]        shamt;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  shifter_unit #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input int s);
    case (o)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return 32'($signed(x) >>> s);
`ifdef SHIFTER_ROTATE_EN
      default: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
`else
      default: return x;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input int s);
`ifndef SHIFTER_ROTATE_EN
    if (o == 2'b11) return 1;
`endif
    return (s + STEP - 1) / STEP + 1;
  endfunction

  // Entered just after a falling edge with the unit idle; leaves just after a falling edge, idle.
  task automatic run(input logic [1:0] o, input logic [31:0] x, input int s,
                     input int hold, input string tag);
    logic [31:0] exp;
    int          lat, explat;
    bit          seen;
    exp    = model(o, x, s);
    explat = model_lat(o, s);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = x; shamt = 5'(s);
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 2'($urandom); a = $urandom; shamt = 5'($urandom);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      chk({tag, ".busy_wait"}, {31'b0, busy}, 32'd1);
      chk({tag, ".result_masked"}, result, 32'd0);
      lat++;
    end
    chk({tag, ".out_valid_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(explat));
    chk({tag, ".result"}, result, exp);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".hold_result"}, result, exp);
        chk({tag, ".hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        in_valid = ~in_valid;
        a = $urandom; shamt = 5'($urandom); op = 2'($urandom);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, ".post_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".post_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, ".post_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, ".post_result"}, result, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; shamt = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset.result", result, 32'd0);
    rst = 1'b0;

    // First request right after reset release.
    run(2'b00, 32'h0000_0001, 31, 0, "sll31");
    run(2'b10, 32'h8000_0000, 4, 0, "sra4");
    run(2'b01, 32'h8000_0000, 4, 0, "srl4");
    for (int o = 0; o < 4; o++) run(2'(o), 32'hDEAD_BEEF, 0, 0, "zero_shamt");
    run(2'b01, 32'hF0F0_F0F0, 7, 5, "hold");
    run(2'b11, 32'h0000_0001, 1, 0, "ror1");
    run(2'b11, 32'h8000_0001, 31, 0, "ror31");
    run(2'b10, 32'h8000_0000, 31, 0, "sra31");
    run(2'b00, 32'h1234_5678, 5, 0, "sll5");
    run(2'b01, 32'h1234_5678, 8, 0, "srl8");

    // Reset in the middle of a long shift discards it.
    in_valid = 1'b1; op = 2'b00; a = 32'h0000_0003; shamt = 5'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.busy_before", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.busy", {31'b0, busy}, 32'd0);
    chk("rst_mid.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_mid.no_valid", {31'b0, out_valid}, 32'd0);
    end
    run(2'b01, 32'h0000_0100, 8, 0, "after_rst");

    for (int t = 0; t < 60; t++)
      run(2'($urandom), $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
